// File: rtl/clk_pkg.sv
// Shared constants for the clock-duty monitor and the divider it watches.
package clk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_MEAS_HIGH = 2'd1;
    localparam state_t ST_MEAS_LOW  = 2'd2;

    // Divider defaults: three cycles high, three cycles low, exact match.
    localparam int DEF_EXP_HIGH = 3;
    localparam int DEF_EXP_LOW  = 3;
    localparam int DEF_TOL      = 0;

    localparam int GOOD_W = 4;

endpackage

// File: rtl/edge_sync.sv
// Samples the observed clock through a short flop chain and flags its edges.
module edge_sync #(
    parameter int SYNC_STAGES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // Shift d_i in at bit 0; the oldest sample drops off the top.
            sync_q <= SYNC_STAGES'({sync_q, d_i});
            prev_q <= s;
        end
    end

    assign rise_o = s & ~prev_q;
    assign fall_o = ~s & prev_q;

endmodule

// File: rtl/clk_duty_monitor.sv
// Measures high/low phase widths of a divided clock, flags deviations,
// reports stalls and declares lock after a run of good periods.
module clk_duty_monitor
    import clk_pkg::*;
#(
    parameter int EXP_HIGH    = DEF_EXP_HIGH,
    parameter int EXP_LOW     = DEF_EXP_LOW,
    parameter int TOL         = DEF_TOL,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255,
    parameter int LOCK_COUNT  = 4,
    parameter int SYNC_STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_valid,
    output logic             err_high,
    output logic             err_low,
    output logic             stall,
    output logic             locked
);

    localparam int CW1 = CNT_W + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
    localparam logic [CNT_W:0]    EXP_HIGH_C = CW1'(EXP_HIGH);
    localparam logic [CNT_W:0]    EXP_LOW_C  = CW1'(EXP_LOW);
    localparam logic [CNT_W:0]    TOL_C      = CW1'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_C     = GOOD_W'(LOCK_COUNT);

    logic rise, fall;
    logic rise_q, fall_q;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (clk_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0]  meas_high_q, meas_high_d;
    logic [CNT_W-1:0]  meas_low_q, meas_low_d;
    logic              meas_valid_q, meas_valid_d;
    logic              err_high_q, err_high_d;
    logic              err_low_q, err_low_d;
    logic              stall_q, stall_d;
    logic              locked_q, locked_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic [CNT_W:0] hi_ext, lo_ext, diff_high, diff_low;
    logic           bad_high, bad_low, timeout_hit;

    // Widths are compared one bit wider so the absolute difference never wraps.
    always_comb begin
        hi_ext    = {1'b0, hi_q};
        lo_ext    = {1'b0, cnt_q};
        diff_high = (hi_ext >= EXP_HIGH_C) ? hi_ext - EXP_HIGH_C : EXP_HIGH_C - hi_ext;
        diff_low  = (lo_ext >= EXP_LOW_C)  ? lo_ext - EXP_LOW_C  : EXP_LOW_C  - lo_ext;
        bad_high  = diff_high > TOL_C;
        bad_low   = diff_low  > TOL_C;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        meas_high_d  = meas_high_q;
        meas_low_d   = meas_low_q;
        meas_valid_d = 1'b0;
        err_high_d   = 1'b0;
        err_low_d    = 1'b0;
        stall_d      = stall_q;
        good_d       = good_q;
        timeout_hit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    state_d = ST_MEAS_HIGH;
                    cnt_d   = ONE_C;
                    stall_d = 1'b0;
                end else if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_q + ONE_C;
                end else if (!stall_q) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_MEAS_HIGH: begin
                if (fall_q) begin
                    hi_d    = cnt_q;
                    cnt_d   = ONE_C;
                    state_d = ST_MEAS_LOW;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            ST_MEAS_LOW: begin
                if (rise_q) begin
                    meas_high_d  = hi_q;
                    meas_low_d   = cnt_q;
                    meas_valid_d = 1'b1;
                    err_high_d   = bad_high;
                    err_low_d    = bad_low;
                    cnt_d        = ONE_C;
                    state_d      = ST_MEAS_HIGH;
                    if (bad_high || bad_low) begin
                        good_d = '0;
                    end else if (good_q != LOCK_C) begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (timeout_hit) begin
            stall_d = 1'b1;
            good_d  = '0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        locked_d = (good_d == LOCK_C);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            meas_high_q  <= '0;
            meas_low_q   <= '0;
            meas_valid_q <= 1'b0;
            err_high_q   <= 1'b0;
            err_low_q    <= 1'b0;
            stall_q      <= 1'b0;
            locked_q     <= 1'b0;
            good_q       <= '0;
        end else begin
            rise_q       <= rise;
            fall_q       <= fall;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            meas_high_q  <= meas_high_d;
            meas_low_q   <= meas_low_d;
            meas_valid_q <= meas_valid_d;
            err_high_q   <= err_high_d;
            err_low_q    <= err_low_d;
            stall_q      <= stall_d;
            locked_q     <= locked_d;
            good_q       <= good_d;
        end
    end

    assign meas_high  = meas_high_q;
    assign meas_low   = meas_low_q;
    assign meas_valid = meas_valid_q;
    assign err_high   = err_high_q;
    assign err_low    = err_low_q;
    assign stall      = stall_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clk_duty_monitor.sv
// Directed bench for clk_duty_monitor: lock, error, tolerance, stall, reset and deep-sync cases.
module tb_clk_duty_monitor;

    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic cin0  = 1'b0;
    logic cin2  = 1'b0;

    logic [CNT_W-1:0] mh0, ml0, mh1, ml1, mh2, ml2;
    logic mv0, eh0, el0, st0, lk0;
    logic mv1, eh1, el1, st1, lk1;
    logic mv2, eh2, el2, st2, lk2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    clk_duty_monitor dut0 (
        .clk(clk), .reset(reset), .clk_in(cin0),
        .meas_high(mh0), .meas_low(ml0), .meas_valid(mv0),
        .err_high(eh0), .err_low(el0), .stall(st0), .locked(lk0)
    );

    clk_duty_monitor #(.TOL(1)) dut1 (
        .clk(clk), .reset(reset), .clk_in(cin0),
        .meas_high(mh1), .meas_low(ml1), .meas_valid(mv1),
        .err_high(eh1), .err_low(el1), .stall(st1), .locked(lk1)
    );

    clk_duty_monitor #(.EXP_HIGH(2), .EXP_LOW(5), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .reset(reset), .clk_in(cin2),
        .meas_high(mh2), .meas_low(ml2), .meas_valid(mv2),
        .err_high(eh2), .err_low(el2), .stall(st2), .locked(lk2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event log filled just after each rising clk edge.
    int mv_cnt0 = 0, err_cnt0 = 0, last_mv_cyc0 = 0, prev_mv_cyc0 = 0;
    int last_mh0 = 0, last_ml0 = 0, last_eh0 = 0, last_el0 = 0;
    int last_lock0 = 0, last_lock_prev0 = 0, lock_rise_mv0 = 0;
    int stall_rise_cyc0 = 0, stall_fall_cyc0 = 0, stall_rises0 = 0;
    logic lk_prev0 = 1'b0, st_prev0 = 1'b0;
    int last_mh1 = 0, last_eh1 = 0;
    int mv_cnt2 = 0, last_mv_cyc2 = 0, last_mh2 = 0, last_ml2 = 0, last_eh2 = 0, last_el2 = 0;
    int rise_cyc0 = 0, rise_cyc2 = 0;

    always @(posedge clk) begin
        #2;
        if (mv0) begin
            mv_cnt0++;
            prev_mv_cyc0    = last_mv_cyc0;
            last_mv_cyc0    = cyc;
            last_mh0        = int'(mh0);
            last_ml0        = int'(ml0);
            last_eh0        = int'(eh0);
            last_el0        = int'(el0);
            last_lock0      = int'(lk0);
            last_lock_prev0 = int'(lk_prev0);
            if (eh0 || el0) err_cnt0++;
        end
        if (lk0 && !lk_prev0) lock_rise_mv0 = mv_cnt0;
        if (st0 && !st_prev0) begin
            stall_rise_cyc0 = cyc;
            stall_rises0++;
        end
        if (!st0 && st_prev0) stall_fall_cyc0 = cyc;
        lk_prev0 = lk0;
        st_prev0 = st0;
        if (mv1) begin
            last_mh1 = int'(mh1);
            last_eh1 = int'(eh1);
        end
        if (mv2) begin
            mv_cnt2++;
            last_mv_cyc2 = cyc;
            last_mh2     = int'(mh2);
            last_ml2     = int'(ml2);
            last_eh2     = int'(eh2);
            last_el2     = int'(el2);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a falling clk edge; leaves the bench on a falling edge.
    task automatic drive0(input int h, input int l);
        if (!cin0) rise_cyc0 = cyc;
        cin0 = 1'b1;
        repeat (h) @(negedge clk);
        cin0 = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic drive2(input int h, input int l);
        if (!cin2) rise_cyc2 = cyc;
        cin2 = 1'b1;
        repeat (h) @(negedge clk);
        cin2 = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_meas_valid", int'(mv0), 0);
        check("reset_meas_high", int'(mh0), 0);
        check("reset_meas_low", int'(ml0), 0);
        check("reset_locked", int'(lk0), 0);
        check("reset_stall", int'(st0), 0);
        check("reset_err_high", int'(eh0), 0);
        reset = 1'b0;
        @(negedge clk);

        // Nominal 3/3 clock: lock on the fourth report.
        repeat (5) drive0(3, 3);
        check("nom_mv_count", mv_cnt0, 4);
        check("nom_meas_high", last_mh0, 3);
        check("nom_meas_low", last_ml0, 3);
        check("nom_err_count", err_cnt0, 0);
        check("nom_lock_at_mv", lock_rise_mv0, 4);
        check("nom_locked", int'(lk0), 1);
        check("nom_latency", last_mv_cyc0 - rise_cyc0, 3);
        check("nom_spacing", last_mv_cyc0 - prev_mv_cyc0, 6);
        check("tol1_locked", int'(lk1), 1);

        // One 4/3 period; its report arrives at the following rise.
        drive0(4, 3);
        drive0(3, 3);
        check("bad_mv_count", mv_cnt0, 6);
        check("bad_meas_high", last_mh0, 4);
        check("bad_meas_low", last_ml0, 3);
        check("bad_err_high", last_eh0, 1);
        check("bad_err_low", last_el0, 0);
        check("bad_lock_at_mv", last_lock0, 0);
        check("bad_lock_before", last_lock_prev0, 1);
        check("tol1_meas_high", last_mh1, 4);
        check("tol1_err_high", last_eh1, 0);
        check("tol1_still_locked", int'(lk1), 1);

        repeat (4) drive0(3, 3);
        check("relock_at_mv", lock_rise_mv0, 10);
        check("relock_locked", int'(lk0), 1);

        // Hold high 300 cycles: stall 255 cycles after the count starts.
        drive0(300, 3);
        check("stall_delay", stall_rise_cyc0 - rise_cyc0, 258);
        check("stall_level", int'(st0), 1);
        check("stall_unlocked", int'(lk0), 0);
        check("stall_once", stall_rises0, 1);
        check("stall_mv_count", mv_cnt0, 11);
        check("stall_tol1_unlocked", int'(lk1), 0);

        drive0(3, 3);
        check("unstall_delay", stall_fall_cyc0 - rise_cyc0, 3);
        check("unstall_level", int'(st0), 0);
        check("unstall_no_report", mv_cnt0, 11);
        drive0(3, 3);
        check("restart_mv_count", mv_cnt0, 12);
        check("restart_meas_high", last_mh0, 3);
        check("restart_meas_low", last_ml0, 3);
        check("restart_latency", last_mv_cyc0 - rise_cyc0, 3);

        // Reset while measuring the low phase.
        drive0(3, 3);
        check("pre_reset_mv_count", mv_cnt0, 13);
        reset = 1'b1;
        #1;
        check("midrst_meas_high", int'(mh0), 0);
        check("midrst_meas_low", int'(ml0), 0);
        check("midrst_meas_valid", int'(mv0), 0);
        check("midrst_locked", int'(lk0), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive0(3, 3);
        check("postrst_no_report", mv_cnt0, 13);
        drive0(3, 3);
        check("postrst_mv_count", mv_cnt0, 14);
        check("postrst_meas_high", last_mh0, 3);
        check("postrst_meas_low", last_ml0, 3);
        check("postrst_latency", last_mv_cyc0 - rise_cyc0, 3);

        // Three sync stages, 2/5 clock.
        repeat (3) drive2(2, 5);
        check("sync3_mv_count", mv_cnt2, 2);
        check("sync3_meas_high", last_mh2, 2);
        check("sync3_meas_low", last_ml2, 5);
        check("sync3_err_high", last_eh2, 0);
        check("sync3_err_low", last_el2, 0);
        check("sync3_latency", last_mv_cyc2 - rise_cyc2, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
